// File: rtl/rom_fetch_sequencer.sv
// Purpose : program sequencer between the combinational instruction ROM and the
//           execute stage; owns the PC, resolves NOP delays and JMPs locally.
// Latency : fetch-to-valid 1 cycle; back-to-back issue 1 instruction per 2 cycles.
// Backpr. : valid/ready; an issued word is held stable until accepted, and enable_i
//           cannot withdraw it.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   enable_i       1 = run, 0 = pause fetch and delay countdown
//   restart_i      synchronous restart to P_START (priority just below reset)
//   address_o      ROM address, always equal to the PC
//   instruction_i  ROM data, combinational from address_o
//   instruction_o  instruction presented to the execute stage
//   valid_o        instruction_o valid
//   ready_i        execute stage accepts when valid_o & ready_i
//   pc_o           address the word on instruction_o was fetched from
//   delay_busy_o   high while a NOP delay is being served
//
// Instruction word: op = [27:24], NOP count = [23:0], JMP target = {8'd0, [23:16]}.

module rom_fetch_sequencer #(
  parameter logic [3:0]  P_OP_NOP = 4'd0,
  parameter logic [3:0]  P_OP_JMP = 4'd1,
  parameter logic [15:0] P_START  = 16'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        restart_i,
  output logic [15:0] address_o,
  input  logic [27:0] instruction_i,
  output logic [27:0] instruction_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [15:0] pc_o,
  output logic        delay_busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DELAY = 2'd3
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [27:0] instr_q;
  logic [15:0] issue_pc_q;
  logic        valid_q;
  logic        busy_q;
  logic [23:0] cnt_q;

  // Decode of the word currently returned by the ROM; only consumed in FETCH.
  logic [3:0]  op_d;
  logic [23:0] nop_cnt_d;
  logic [15:0] jmp_tgt_d;
  logic [15:0] pc_inc_d;

  always_comb begin
    op_d      = instruction_i[27:24];
    nop_cnt_d = instruction_i[23:0];
    jmp_tgt_d = {8'd0, instruction_i[23:16]};
    // 16-bit add wraps FFFF -> 0000 naturally.
    pc_inc_d  = pc_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= P_START;
      instr_q    <= 28'd0;
      issue_pc_q <= 16'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= 24'd0;
    end else if (restart_i) begin
      // A handshake on this same edge is still taken by execute (valid/ready were
      // both high), but the program restarts regardless.
      pc_q    <= P_START;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 24'd0;
      state_q <= enable_i ? S_FETCH : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            state_q <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (enable_i) begin
            if (op_d == P_OP_NOP) begin
              if (nop_cnt_d == 24'd0) begin
                pc_q <= pc_inc_d;
              end else begin
                cnt_q   <= nop_cnt_d;
                busy_q  <= 1'b1;
                state_q <= S_DELAY;
              end
            end else if (op_d == P_OP_JMP) begin
              // JMP is consumed here and never reaches the execute stage.
              pc_q <= jmp_tgt_d;
            end else begin
              instr_q    <= instruction_i;
              issue_pc_q <= pc_q;
              valid_q    <= 1'b1;
              state_q    <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          // enable_i deliberately not consulted: a presented word must be accepted
          // before the sequencer may pause.
          if (ready_i) begin
            valid_q <= 1'b0;
            pc_q    <= pc_inc_d;
            state_q <= S_FETCH;
          end
        end

        S_DELAY: begin
          if (enable_i) begin
            // Leaving on the edge where the counter reads 1 makes a count of N
            // occupy exactly N cycles in DELAY.
            if (cnt_q == 24'd1) begin
              cnt_q   <= 24'd0;
              busy_q  <= 1'b0;
              pc_q    <= pc_inc_d;
              state_q <= S_FETCH;
            end else begin
              cnt_q <= cnt_q - 24'd1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign address_o     = pc_q;
  assign instruction_o = instr_q;
  assign valid_o       = valid_q;
  assign pc_o          = issue_pc_q;
  assign delay_busy_o  = busy_q;

endmodule
